// File: rtl/muldiv_seq_unit.sv
// Iterative RV M-extension unit: radix-2 shift-add multiply, restoring divide,
// with single-cycle results for divide-by-zero and signed overflow.
module muldiv_seq_unit #(
    parameter int         XLEN      = 32,
    parameter logic [2:0] R_TYPE_OP = 3'b000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_alu_op,
    input  logic [2:0]      i_funct3,
    input  logic [6:0]      i_funct7,
    output logic            o_is_muldiv,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_kill,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic [2:0]        f3_q, f3_d;
    logic              neg_q, neg_d;

    logic              accept;
    logic              a_sgn, b_sgn;
    logic              a_neg, b_neg;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum, div_diff;
    logic [2*XLEN-1:0] mul_step, div_step, prod_fix;
    logic [XLEN-1:0]   mul_res, div_raw, div_res;

    assign o_is_muldiv = (i_alu_op == R_TYPE_OP) && (i_funct7 == 7'b0000001);
    assign accept      = (state_q == S_IDLE) & i_valid & o_is_muldiv & ~i_kill;

    // Which operands are interpreted as signed for each funct3
    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        unique case (i_funct3)
            3'b001:         begin a_sgn = 1'b1; b_sgn = 1'b1; end
            3'b010:         a_sgn = 1'b1;
            3'b100, 3'b110: begin a_sgn = 1'b1; b_sgn = 1'b1; end
            default:        ;
        endcase
    end

    assign a_neg    = a_sgn & i_rs1[XLEN-1];
    assign b_neg    = b_sgn & i_rs2[XLEN-1];
    assign a_mag    = a_neg ? -i_rs1 : i_rs1;
    assign b_mag    = b_neg ? -i_rs2 : i_rs2;
    assign div_zero = ~|i_rs2;
    assign div_ovf  = (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (&i_rs2);

    // acc = {partial product, remaining multiplier bits}
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]}
                    + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_step = {mul_sum, acc_q[XLEN-1:1]};
    assign prod_fix = neg_q ? -mul_step : mul_step;
    assign mul_res  = (f3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0]
                                           : prod_fix[2*XLEN-1:XLEN];

    // acc = {partial remainder, dividend bits / quotient bits}
    assign div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
    assign div_step = div_diff[XLEN]
                    ? {acc_q[2*XLEN-2:0], 1'b0}
                    : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    assign div_raw  = f3_q[1] ? div_step[2*XLEN-1:XLEN] : div_step[XLEN-1:0];
    assign div_res  = neg_q ? -div_raw : div_raw;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        res_d   = res_q;
        f3_d    = f3_q;
        neg_d   = neg_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    f3_d  = i_funct3;
                    cnt_d = CW'(XLEN - 1);
                    if (!i_funct3[2]) begin
                        acc_d   = {{XLEN{1'b0}}, b_mag};
                        opb_d   = a_mag;
                        neg_d   = a_neg ^ b_neg;
                        state_d = S_MUL;
                    end else if (div_zero) begin
                        res_d   = i_funct3[1] ? i_rs1 : '1;
                        state_d = S_DONE;
                    end else if (div_ovf && !i_funct3[0]) begin
                        res_d   = i_funct3[1] ? '0 : i_rs1;
                        state_d = S_DONE;
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, a_mag};
                        opb_d   = b_mag;
                        neg_d   = i_funct3[1] ? a_neg : (a_neg ^ b_neg);
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    res_d   = mul_res;
                    state_d = S_DONE;
                end
            end
            S_DIV: begin
                acc_d = div_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    res_d   = div_res;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (i_kill) begin
            state_d = S_IDLE;
            res_d   = res_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            f3_q    <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            f3_q    <= f3_d;
            neg_q   <= neg_d;
        end
    end

    assign o_ready  = (state_q == S_IDLE) & ~i_rst;
    assign o_busy   = (state_q != S_IDLE);
    assign o_done   = (state_q == S_DONE);
    assign o_result = res_q;

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Bench for muldiv_seq_unit: vector table plus scoreboard of expected
// results and completion cycles, with hand sequences for kill/reset/filtering.
module tb_muldiv_seq_unit;

    logic        clk = 1'b0;
    logic        rst, valid, kill, valid16;
    logic [2:0]  alu_op, funct3;
    logic [6:0]  funct7;
    logic [31:0] rs1, rs2, result;
    logic        ready, is_md, busy, done;
    logic [15:0] rs1_16, rs2_16, result16;
    logic        ready16, is_md16, busy16, done16;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        int          at;
    } exp_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[17];

    muldiv_seq_unit #(.XLEN(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready),
        .i_alu_op(alu_op), .i_funct3(funct3), .i_funct7(funct7),
        .o_is_muldiv(is_md), .i_rs1(rs1), .i_rs2(rs2), .i_kill(kill),
        .o_busy(busy), .o_done(done), .o_result(result)
    );

    muldiv_seq_unit #(.XLEN(16)) dut16 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid16), .o_ready(ready16),
        .i_alu_op(alu_op), .i_funct3(funct3), .i_funct7(funct7),
        .o_is_muldiv(is_md16), .i_rs1(rs1_16), .i_rs2(rs2_16), .i_kill(1'b0),
        .o_busy(busy16), .o_done(done16), .o_result(result16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    // Scoreboard: every o_done must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", 32'(cyc), 32'(e.at));
                chk("done_result", result, e.res);
            end
        end
    end

    task automatic issue(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res,
                         input int lat, input bit push, output int c);
        exp_t e;
        @(negedge clk);
        funct3 = f3;
        rs1    = a;
        rs2    = b;
        valid  = 1'b1;
        c      = cyc;
        if (push) begin
            e.res = res;
            e.at  = c + lat;
            sb.push_back(e);
        end
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d pending results, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int c;
        int n;
        bit ok;

        tbl[0]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
        tbl[1]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        tbl[2]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        tbl[3]  = '{3'b001, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 33};
        tbl[4]  = '{3'b000, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 33};
        tbl[5]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
        tbl[6]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
        tbl[7]  = '{3'b101, 32'd100,       32'd7,         32'd14,        33};
        tbl[8]  = '{3'b111, 32'd100,       32'd7,         32'd2,         33};
        tbl[9]  = '{3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         33};
        tbl[10] = '{3'b101, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33};
        tbl[11] = '{3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        tbl[12] = '{3'b111, 32'd5,         32'd0,         32'd5,         1};
        tbl[13] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        tbl[14] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
        tbl[15] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33};
        tbl[16] = '{3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1};

        rst     = 1'b1;
        valid   = 1'b0;
        kill    = 1'b0;
        valid16 = 1'b0;
        alu_op  = 3'b000;
        funct3  = 3'b000;
        funct7  = 7'b0000001;
        rs1     = '0;
        rs2     = '0;
        rs1_16  = '0;
        rs2_16  = '0;

        repeat (3) @(negedge clk);
        chk1("ready_in_reset", ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_done", done, 1'b0);
        chk("reset_result", result, 32'd0);
        chk1("reset_ready", ready, 1'b1);

        // MUL 7 x -3 with o_ready window check
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b1, c);
        ok = 1'b1;
        while (cyc <= c + 33) begin
            if (ready) ok = 1'b0;
            @(negedge clk);
        end
        chk1("ready_low_window", ok, 1'b1);
        chk1("ready_back", ready, 1'b1);
        wait_idle(5);

        for (int i = 0; i < 17; i++) begin
            issue(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].res,
                  tbl[i].lat, 1'b1, c);
            wait_idle(tbl[i].lat + 5);
        end

        // Non-M instructions must be ignored
        @(negedge clk);
        funct7 = 7'b0100000;
        valid  = 1'b1;
        #1 chk1("is_md_sub", is_md, 1'b0);
        repeat (3) @(negedge clk);
        chk1("sub_not_busy", busy, 1'b0);
        valid  = 1'b0;
        funct7 = 7'b0000001;
        alu_op = 3'b011;
        #1 chk1("is_md_itype", is_md, 1'b0);
        alu_op = 3'b000;
        #1 chk1("is_md_mext", is_md, 1'b1);

        // i_valid held high: accepts at C and C+34 only
        @(negedge clk);
        funct3 = 3'b000;
        rs1    = 32'd3;
        rs2    = 32'd5;
        valid  = 1'b1;
        c      = cyc;
        sb.push_back('{32'd15, c + 33});
        sb.push_back('{32'd15, c + 67});
        while (cyc < c + 41) @(negedge clk);
        valid = 1'b0;
        wait_idle(60);
        repeat (40) @(negedge clk);

        // Kill mid-divide
        issue(3'b101, 32'd1000, 32'd3, 32'd0, 0, 1'b0, c);
        while (cyc < c + 10) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk1("kill_ready", ready, 1'b1);
        chk1("kill_busy", busy, 1'b0);
        chk("kill_result_held", result, 32'd15);
        repeat (40) @(negedge clk);
        issue(3'b000, 32'd3, 32'd4, 32'd12, 33, 1'b1, c);
        wait_idle(40);

        // Reset mid-divide
        issue(3'b101, 32'd1000, 32'd3, 32'd0, 0, 1'b0, c);
        while (cyc < c + 10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_result", result, 32'd0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        rst = 1'b0;
        #1 chk1("rst_ready", ready, 1'b1);
        repeat (40) @(negedge clk);

        // XLEN=16 instance: MUL and MULHU of 300 x 300
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            funct3  = (k == 0) ? 3'b000 : 3'b011;
            rs1_16  = 16'd300;
            rs2_16  = 16'd300;
            valid16 = 1'b1;
            c       = cyc;
            @(negedge clk);
            valid16 = 1'b0;
            n = 0;
            while (!done16 && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("x16_done_cycle", 32'(cyc), 32'(c + 17));
            chk("x16_result", {16'd0, result16},
                (k == 0) ? 32'h0000_5F90 : 32'h0000_0001);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
